// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALU control and datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OPC_R    = 6'd0;
  localparam logic [5:0] OPC_J    = 6'd2;
  localparam logic [5:0] OPC_BEQ  = 6'd4;
  localparam logic [5:0] OPC_ADDI = 6'd8;
  localparam logic [5:0] OPC_LW   = 6'd35;
  localparam logic [5:0] OPC_SW   = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_t;

  // Widen a 6-bit opcode constant to the instantiated op field width.
  function automatic logic [31:0] opc_ext(logic [5:0] opc);
    return {26'd0, opc};
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, mux selects and enables out.
interface multicycle_control_if #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
);
  logic [OP_W-1:0]  op;
  logic             mem_ready;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             pcwrite;
  logic             branch;
  logic [1:0]       pcsrc;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  op, mem_ready,
    output iord, memread, memwrite, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
           retire, illegal, instr_count
  );

  modport slave (
    output op, mem_ready,
    input  iord, memread, memwrite, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
           retire, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control_retire_counter.sv
// Free-running retired-instruction counter; wraps at 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps illegal opcodes and counts retired instructions.
//
// state    | meaning
// FETCH    | read instr at PC, PC+4; leave when memory ready
// DECODE   | register read, branch target precompute, dispatch on op
// MEMADR   | lw/sw effective address
// MEMRD    | load data read, wait for ready
// MEMWB    | load writeback, retire
// MEMWR    | store write, retire on ready
// EXEC     | R-type ALU operation
// ALUWB    | R-type writeback to rd, retire
// ADDIEX   | addi ALU operation
// ADDIWB   | addi writeback to rt, retire
// BRANCH   | beq compare and conditional PC load, retire
// JUMP     | PC load from jump target, retire
// TRAP     | illegal opcode, parked until reset
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int CNT_W       = 32,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  ctrl_state_t state, state_nxt;

  logic       iord, memread, memwrite, irwrite, pcwrite, branch;
  logic       alusrca, regdst, memtoreg, regwrite, retire, illegal;
  logic [1:0] pcsrc, alusrcb, aluop;

  logic op_lw, op_sw, op_r, op_addi, op_beq, op_j;

  assign op_lw   = (bus.op == OP_W'(opc_ext(OPC_LW)));
  assign op_sw   = (bus.op == OP_W'(opc_ext(OPC_SW)));
  assign op_r    = (bus.op == OP_W'(opc_ext(OPC_R)));
  assign op_addi = (bus.op == OP_W'(opc_ext(OPC_ADDI)));
  assign op_beq  = (bus.op == OP_W'(opc_ext(OPC_BEQ)));
  assign op_j    = (bus.op == OP_W'(opc_ext(OPC_J)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iord      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    pcsrc     = PCSRC_ALU;
    alusrca   = 1'b0;
    alusrcb   = SRCB_RT;
    aluop     = ALUOP_ADD;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        if (op_lw || op_sw)            state_nxt = S_MEMADR;
        else if (op_r)                 state_nxt = S_EXEC;
        else if (op_addi)              state_nxt = S_ADDIEX;
        else if (op_beq)               state_nxt = S_BRANCH;
        else if (op_j && ENABLE_JUMP)  state_nxt = S_JUMP;
        else                           state_nxt = S_TRAP;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        // op is re-examined here; a non-memory opcode at this point is treated as illegal
        if (op_lw)      state_nxt = S_MEMRD;
        else if (op_sw) state_nxt = S_MEMWR;
        else            state_nxt = S_TRAP;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (bus.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite  = 1'b1;
        memtoreg  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_EXEC: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        regdst    = 1'b1;
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = SRCB_IMM;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        pcsrc     = PCSRC_ALUOUT;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pcwrite   = 1'b1;
        pcsrc     = PCSRC_JUMP;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: begin
        illegal   = 1'b1;
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign bus.iord     = iord;
  assign bus.memread  = memread;
  assign bus.memwrite = memwrite;
  assign bus.irwrite  = irwrite;
  assign bus.pcwrite  = pcwrite;
  assign bus.branch   = branch;
  assign bus.pcsrc    = pcsrc;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.aluop    = aluop;
  assign bus.regdst   = regdst;
  assign bus.memtoreg = memtoreg;
  assign bus.regwrite = regwrite;
  assign bus.retire   = retire;
  assign bus.illegal  = illegal;

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .count (bus.instr_count)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle control-word checks against an instruction-level
// step model, three instances (32-bit count, 4-bit count, jump disabled) on shared stimulus.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;

  always #5 clk = ~clk;

  multicycle_control_if #(.OP_W(6), .CNT_W(32)) ifa ();
  multicycle_control_if #(.OP_W(6), .CNT_W(4))  ifb ();
  multicycle_control_if #(.OP_W(6), .CNT_W(32)) ifc ();

  assign ifa.op = op;  assign ifa.mem_ready = mem_ready;
  assign ifb.op = op;  assign ifb.mem_ready = mem_ready;
  assign ifc.op = op;  assign ifc.mem_ready = mem_ready;

  multicycle_control #(.OP_W(6), .CNT_W(32), .ENABLE_JUMP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  multicycle_control #(.OP_W(6), .CNT_W(4),  .ENABLE_JUMP(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  multicycle_control #(.OP_W(6), .CNT_W(32), .ENABLE_JUMP(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  wire [17:0] obs_a = {ifa.iord, ifa.memread, ifa.memwrite, ifa.irwrite, ifa.pcwrite, ifa.branch,
                       ifa.pcsrc, ifa.alusrca, ifa.alusrcb, ifa.aluop, ifa.regdst, ifa.memtoreg,
                       ifa.regwrite, ifa.retire, ifa.illegal};
  wire [17:0] obs_b = {ifb.iord, ifb.memread, ifb.memwrite, ifb.irwrite, ifb.pcwrite, ifb.branch,
                       ifb.pcsrc, ifb.alusrca, ifb.alusrcb, ifb.aluop, ifb.regdst, ifb.memtoreg,
                       ifb.regwrite, ifb.retire, ifb.illegal};

  // Instruction steps as the datapath sees them
  localparam int P_F = 0, P_D = 1, P_A = 2, P_MR = 3, P_MWB = 4, P_MW = 5, P_EX = 6,
                 P_AWB = 7, P_IEX = 8, P_IWB = 9, P_BR = 10, P_J = 11, P_T = 12;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_cnt = 0;
  int          q_ph[$];
  logic        q_mr[$];
  logic [5:0]  ops_tbl[6] = '{6'd35, 6'd43, 6'd0, 6'd8, 6'd4, 6'd2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_vec(int ph, logic mr);
    logic iord, memread, memwrite, irwrite, pcwrite, branch, alusrca;
    logic regdst, memtoreg, regwrite, retire, illegal;
    logic [1:0] pcsrc, alusrcb, aluop;
    {iord, memread, memwrite, irwrite, pcwrite, branch, alusrca} = '0;
    {regdst, memtoreg, regwrite, retire, illegal} = '0;
    pcsrc = 2'b00; alusrcb = 2'b00; aluop = 2'b00;
    case (ph)
      P_F:   begin memread = 1; alusrcb = 2'b01; irwrite = mr; pcwrite = mr; end
      P_D:   alusrcb = 2'b11;
      P_A:   begin alusrca = 1; alusrcb = 2'b10; end
      P_MR:  begin iord = 1; memread = 1; end
      P_MWB: begin regwrite = 1; memtoreg = 1; retire = 1; end
      P_MW:  begin iord = 1; memwrite = 1; retire = mr; end
      P_EX:  begin alusrca = 1; aluop = 2'b10; end
      P_AWB: begin regdst = 1; regwrite = 1; retire = 1; end
      P_IEX: begin alusrca = 1; alusrcb = 2'b10; end
      P_IWB: begin regwrite = 1; retire = 1; end
      P_BR:  begin alusrca = 1; aluop = 2'b01; branch = 1; pcsrc = 2'b01; retire = 1; end
      P_J:   begin pcwrite = 1; pcsrc = 2'b10; retire = 1; end
      P_T:   illegal = 1;
      default: ;
    endcase
    return {iord, memread, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
            aluop, regdst, memtoreg, regwrite, retire, illegal};
  endfunction

  task automatic push(input int ph, input logic mr);
    q_ph.push_back(ph);
    q_mr.push_back(mr);
  endtask

  task automatic build(input logic [5:0] o, input int fst, input int mst);
    q_ph.delete();
    q_mr.delete();
    for (int i = 0; i < fst; i++) push(P_F, 1'b0);
    push(P_F, 1'b1);
    push(P_D, 1'($urandom));
    case (o)
      6'd35: begin
        push(P_A, 1'($urandom));
        for (int i = 0; i < mst; i++) push(P_MR, 1'b0);
        push(P_MR, 1'b1);
        push(P_MWB, 1'($urandom));
      end
      6'd43: begin
        push(P_A, 1'($urandom));
        for (int i = 0; i < mst; i++) push(P_MW, 1'b0);
        push(P_MW, 1'b1);
      end
      6'd0:    begin push(P_EX, 1'($urandom)); push(P_AWB, 1'($urandom)); end
      6'd8:    begin push(P_IEX, 1'($urandom)); push(P_IWB, 1'($urandom)); end
      6'd4:    push(P_BR, 1'($urandom));
      6'd2:    push(P_J, 1'($urandom));
      default: for (int i = 0; i < 3; i++) push(P_T, 1'($urandom));
    endcase
  endtask

  // Called right after a negedge with the DUT in FETCH; returns at a negedge.
  task automatic run(input string tag, input logic [5:0] o, input int fst, input int mst,
                     input int ncyc);
    build(o, fst, mst);
    for (int i = 0; i < q_ph.size() && i < ncyc; i++) begin
      op        = (q_ph[i] == P_D || q_ph[i] == P_A) ? o : 6'($urandom);
      mem_ready = q_mr[i];
      #1;
      chk({tag, "_ctl_a"}, 32'(obs_a), 32'(exp_vec(q_ph[i], q_mr[i])));
      chk({tag, "_ctl_b"}, 32'(obs_b), 32'(exp_vec(q_ph[i], q_mr[i])));
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] o, input int fst, input int mst);
    bit legal;
    legal = (o == 6'd35 || o == 6'd43 || o == 6'd0 || o == 6'd8 || o == 6'd4 || o == 6'd2);
    run(tag, o, fst, mst, 1000);
    if (legal) model_cnt = model_cnt + 1;
    chk({tag, "_cnt_a"}, ifa.instr_count, model_cnt);
    chk({tag, "_cnt_b"}, 32'(ifb.instr_count), {28'd0, model_cnt[3:0]});
  endtask

  task automatic chk_reset_values(input string tag);
    mem_ready = 1'b0;
    #1;
    chk({tag, "_ctl0"}, 32'(obs_a), 32'(exp_vec(P_F, 1'b0)));
    mem_ready = 1'b1;
    #1;
    chk({tag, "_ctl1"}, 32'(obs_a), 32'(exp_vec(P_F, 1'b1)));
    chk({tag, "_cnt_a"}, ifa.instr_count, 32'd0);
    chk({tag, "_cnt_b"}, 32'(ifb.instr_count), 32'd0);
    chk({tag, "_ill_c"}, 32'(ifc.illegal), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; op = 6'd0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_instr("lw", 6'd35, 0, 0);
    do_instr("sw_stall", 6'd43, 0, 3);
    do_instr("seq_r", 6'd0, 0, 0);
    do_instr("seq_addi", 6'd8, 0, 0);
    do_instr("seq_beq", 6'd4, 0, 0);
    do_instr("seq_j", 6'd2, 0, 0);
    chk("nojump_ill_c", 32'(ifc.illegal), 32'd1);
    chk("nojump_memread_c", 32'(ifc.memread), 32'd0);
    chk("nojump_cnt_c", ifc.instr_count, 32'd5);

    for (int k = 0; k < 40; k++) begin
      do_instr("rand", ops_tbl[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    do_instr("trap63", 6'd63, 1, 0);
    rst_n = 1'b0;
    #1 chk_reset_values("trap_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;

    for (int k = 0; k < 5; k++) do_instr("pre_rd", ops_tbl[$urandom_range(0, 5)], 0, 1);
    run("rd_abort", 6'd35, 0, 2, 3);
    mem_ready = 1'b0;
    #1 chk("in_memrd", 32'(obs_a), 32'(exp_vec(P_MR, 1'b0)));
    #2 rst_n = 1'b0;
    chk_reset_values("memrd_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;

    for (int k = 0; k < 17; k++) do_instr("wrap_j", 6'd2, $urandom_range(0, 1), 0);
    chk("wrap_b", 32'(ifb.instr_count), 32'd1);
    chk("wrap_a", ifa.instr_count, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
